// File: rtl/dual_issue_sequencer_pkg.sv
// Shared types and constants for the dual-issue pair sequencer.
package dual_issue_pkg;

  typedef enum logic {
    PAIR  = 1'b0,
    SPLIT = 1'b1
  } seq_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         PC_STEP  = 4;

endpackage

// File: rtl/dual_issue_sequencer_if.sv
// Decode-pair fields in, issue/stall controls out, between decode and the sequencer.
interface dual_issue_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
);
  logic                  ValidD1;
  logic                  ValidD2;
  logic [ADDR_WIDTH-1:0] PCD1;
  logic [ADDR_WIDTH-1:0] PCD2;
  logic [4:0]            RdD1;
  logic                  RegWriteD1;
  logic                  BranchD1;
  logic [4:0]            Rs1D2;
  logic [4:0]            Rs2D2;
  logic [4:0]            RdD2;
  logic                  RegWriteD2;
  logic                  StallE;
  logic                  FlushD;
  logic                  IssueE1;
  logic                  IssueE2;
  logic                  StallF;
  logic                  StallD;
  logic                  SplitActive;
  logic [CNT_WIDTH-1:0]  SplitCount;

  modport master (
    output ValidD1, ValidD2, PCD1, PCD2, RdD1, RegWriteD1, BranchD1,
           Rs1D2, Rs2D2, RdD2, RegWriteD2, StallE, FlushD,
    input  IssueE1, IssueE2, StallF, StallD, SplitActive, SplitCount
  );

  modport slave (
    input  ValidD1, ValidD2, PCD1, PCD2, RdD1, RegWriteD1, BranchD1,
           Rs1D2, Rs2D2, RdD2, RegWriteD2, StallE, FlushD,
    output IssueE1, IssueE2, StallF, StallD, SplitActive, SplitCount
  );
endinterface

// File: rtl/dual_issue_sequencer_hazard.sv
// Combinational intra-pair dependency flags between slot 1 and slot 2.
module pair_hazard_detect
  import dual_issue_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_pc1,
  input  logic [ADDR_WIDTH-1:0] i_pc2,
  input  logic [4:0]            i_rd1,
  input  logic                  i_reg_write1,
  input  logic                  i_branch1,
  input  logic [4:0]            i_rs1_2,
  input  logic [4:0]            i_rs2_2,
  input  logic [4:0]            i_rd2,
  input  logic                  i_reg_write2,
  output logic                  o_raw_haz,
  output logic                  o_waw_haz,
  output logic                  o_shadow_haz,
  output logic                  o_misalign_haz
);
  logic                  w_rd1_live;
  logic [ADDR_WIDTH-1:0] w_pc_next;

  // x0 writes are architecturally discarded, so they never create a dependency.
  assign w_rd1_live     = i_reg_write1 && (i_rd1 != REG_ZERO);
  assign w_pc_next      = i_pc1 + ADDR_WIDTH'(PC_STEP);

  assign o_raw_haz      = w_rd1_live && ((i_rd1 == i_rs1_2) || (i_rd1 == i_rs2_2));
  assign o_waw_haz      = w_rd1_live && i_reg_write2 && (i_rd1 == i_rd2);
  assign o_shadow_haz   = i_branch1;
  assign o_misalign_haz = (i_pc2 != w_pc_next);
endmodule

// File: rtl/dual_issue_sequencer.sv
// Splits a dependent decode pair over two cycles; counts split events (saturating).
module dual_issue_sequencer
  import dual_issue_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input logic                 clk,
  input logic                 rst,
  dual_issue_sequencer_if.slave bus
);
  seq_state_t           r_state;
  logic [CNT_WIDTH-1:0] r_split_count;

  seq_state_t w_next_state;
  logic       w_count_inc;
  logic       w_issue1;
  logic       w_issue2;
  logic       w_stall;
  logic       w_raw_haz;
  logic       w_waw_haz;
  logic       w_shadow_haz;
  logic       w_misalign_haz;
  logic       w_hazard;

  pair_hazard_detect #(.ADDR_WIDTH(ADDR_WIDTH)) u_hazard (
    .i_pc1          (bus.PCD1),
    .i_pc2          (bus.PCD2),
    .i_rd1          (bus.RdD1),
    .i_reg_write1   (bus.RegWriteD1),
    .i_branch1      (bus.BranchD1),
    .i_rs1_2        (bus.Rs1D2),
    .i_rs2_2        (bus.Rs2D2),
    .i_rd2          (bus.RdD2),
    .i_reg_write2   (bus.RegWriteD2),
    .o_raw_haz      (w_raw_haz),
    .o_waw_haz      (w_waw_haz),
    .o_shadow_haz   (w_shadow_haz),
    .o_misalign_haz (w_misalign_haz)
  );

  assign w_hazard = bus.ValidD1 && bus.ValidD2 &&
                    (w_raw_haz || w_waw_haz || w_shadow_haz || w_misalign_haz);

  always_comb begin
    w_next_state = r_state;
    w_count_inc  = 1'b0;
    w_issue1     = 1'b0;
    w_issue2     = 1'b0;
    w_stall      = 1'b0;
    if (rst) begin
      w_next_state = PAIR;
    end else if (bus.FlushD) begin
      // Wrong-path decode contents: drop everything, including a held slot 2.
      w_next_state = PAIR;
    end else if (bus.StallE) begin
      w_stall = 1'b1;
    end else begin
      case (r_state)
        PAIR: begin
          if (w_hazard) begin
            w_issue1     = 1'b1;
            w_stall      = 1'b1;
            w_next_state = SPLIT;
            w_count_inc  = 1'b1;
          end else begin
            w_issue1 = bus.ValidD1;
            w_issue2 = bus.ValidD2;
          end
        end
        SPLIT: begin
          w_issue2     = 1'b1;
          w_next_state = PAIR;
        end
        default: w_next_state = PAIR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= PAIR;
      r_split_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_count_inc && (r_split_count != {CNT_WIDTH{1'b1}})) begin
        r_split_count <= r_split_count + 1'b1;
      end
    end
  end

  assign bus.IssueE1     = w_issue1;
  assign bus.IssueE2     = w_issue2;
  assign bus.StallF      = w_stall;
  assign bus.StallD      = w_stall;
  assign bus.SplitActive = !rst && (r_state == SPLIT);
  assign bus.SplitCount  = rst ? '0 : r_split_count;
endmodule
